// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the codec I2C write master.
//   - i2c_state_e : bus FSM states
//   - Q_*         : quarter-bit phase values (one I2C bit = BIT_CYCLES clocks)
//   - BYTES_PER_CMD, BIT_CYCLES, CODEC_ADDR (default 7-bit slave address)
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } i2c_state_e;

    localparam logic [1:0] Q_SETUP = 2'd0;  // SCL low, SDA may change
    localparam logic [1:0] Q_HIGH  = 2'd2;  // first SCL-high quarter, sample point
    localparam logic [1:0] Q_LAST  = 2'd3;  // terminal quarter of a bit slot

    localparam int BYTES_PER_CMD = 3;
    localparam int BIT_CYCLES    = 4;

    localparam logic [6:0] CODEC_ADDR = 7'h1A;

endpackage

// File: rtl/i2c_phase_counter.sv
// i2c_phase_counter: mod-4 quarter-bit counter for the I2C write master.
// Ports:
//   i_clk    in   quarter-bit clock
//   i_reset  in   synchronous active-high reset
//   i_clr    in   hold the phase at Q_SETUP (used while idle / done)
//   o_q      out  current phase 0..3
//   o_q_nxt  out  phase the counter will hold next cycle (lets the owner
//                 register its outputs aligned with the phase)
//   o_tc     out  terminal count, high at phase Q_LAST
module i2c_phase_counter
    import i2c_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clr,
    output logic [1:0] o_q,
    output logic [1:0] o_q_nxt,
    output logic       o_tc
);

    logic [1:0] r_q;

    // Free-running wrap 3 -> 0; every bus slot is a whole number of bits.
    assign o_q_nxt = i_clr ? Q_SETUP : r_q + 2'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_q <= Q_SETUP;
        else         r_q <= o_q_nxt;
    end

    assign o_q  = r_q;
    assign o_tc = (r_q == Q_LAST);

endmodule

// File: rtl/i2c_write_master.sv
// i2c_write_master: serializes one codec register write per command onto an
// open-drain I2C bus: START, {DEV_ADDR,W}, SubAddrL, data, STOP, then a
// one-cycle NewCom pulse back to the command sequencer.
// Ports:
//   I2C_clk   in   quarter-bit clock (4 cycles per I2C bit)
//   reset     in   synchronous active-high reset
//   Write     in   command strobe, only looked at in IDLE
//   SubAddrL  in   register sub-address byte
//   data      in   register data byte
//   SDA_in    in   sampled SDA bus level
//   SCL       out  bus clock, 1 = released
//   SDA_oe    out  1 = pull SDA low
//   NewCom    out  one-cycle command-finished pulse
//   Busy      out  high from acceptance through the DONE cycle
//   AckErr    out  sticky NACK flag
// Build option: define I2C_ACK_CHECK_EN to sample the slave ACK and abort to
// STOP on a NACK; otherwise SDA_in is ignored and AckErr is tied low.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = CODEC_ADDR
)
(
    input  logic       I2C_clk,
    input  logic       reset,
    input  logic       Write,
    input  logic [7:0] SubAddrL,
    input  logic [7:0] data,
    input  logic       SDA_in,
    output logic       SCL,
    output logic       SDA_oe,
    output logic       NewCom,
    output logic       Busy,
    output logic       AckErr
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_CMD - 1);

    i2c_state_e  r_state;
    logic [23:0] r_shift;
    logic [2:0]  r_bit;
    logic [1:0]  r_byte;
    logic        r_scl;
    logic        r_sda_oe;
    logic        r_newcom;
    logic        r_busy;

    i2c_state_e  w_state_nxt;
    logic [23:0] w_shift_nxt;
    logic [2:0]  w_bit_nxt;
    logic [1:0]  w_byte_nxt;
    logic        w_scl_nxt;
    logic        w_sda_oe_nxt;
    logic [1:0]  w_q;
    logic [1:0]  w_q_nxt;
    logic        w_tc;
    logic        w_clr;
    logic        w_nack;

    assign w_clr = (r_state == ST_IDLE) || (r_state == ST_DONE);

    i2c_phase_counter u_phase (
        .i_clk   (I2C_clk),
        .i_reset (reset),
        .i_clr   (w_clr),
        .o_q     (w_q),
        .o_q_nxt (w_q_nxt),
        .o_tc    (w_tc)
    );

`ifdef I2C_ACK_CHECK_EN
    logic r_ackerr;

    // Cleared on acceptance, set by a released SDA at the ACK sample point.
    always_ff @(posedge I2C_clk) begin
        if (reset)
            r_ackerr <= 1'b0;
        else if (r_state == ST_IDLE && Write)
            r_ackerr <= 1'b0;
        else if (r_state == ST_ACK && w_q == Q_HIGH && SDA_in)
            r_ackerr <= 1'b1;
    end

    // Only this command's ACK slots can have set it: an earlier NACK already
    // sent the FSM to STOP.
    assign w_nack = r_ackerr;
    assign AckErr = r_ackerr;
`else
    logic w_unused;
    assign w_unused = SDA_in ^ (^w_q);
    assign w_nack   = 1'b0;
    assign AckErr   = 1'b0;
`endif

    // Next-state / datapath
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        case (r_state)
            ST_IDLE: if (Write) begin
                w_state_nxt = ST_START;
                w_shift_nxt = {DEV_ADDR, 1'b0, SubAddrL, data};
                w_bit_nxt   = 3'd0;
                w_byte_nxt  = 2'd0;
            end
            ST_START: if (w_tc) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_tc) begin
                w_shift_nxt = {r_shift[22:0], 1'b0};
                w_bit_nxt   = r_bit + 3'd1;
                if (r_bit == 3'd7) w_state_nxt = ST_ACK;
            end
            ST_ACK: if (w_tc) begin
                if (w_nack || r_byte == LAST_BYTE) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_byte_nxt  = r_byte + 2'd1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_STOP: if (w_tc) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus levels are decoded from the *next* state and phase so that the
    // registered pins line up with the state they belong to.
    always_comb begin
        w_scl_nxt    = 1'b1;
        w_sda_oe_nxt = 1'b0;
        case (w_state_nxt)
            ST_START: w_sda_oe_nxt = w_q_nxt[1];
            ST_SHIFT: begin
                w_scl_nxt    = w_q_nxt[1];
                w_sda_oe_nxt = ~w_shift_nxt[23];
            end
            ST_ACK:   w_scl_nxt = w_q_nxt[1];
            ST_STOP: begin
                w_scl_nxt    = w_q_nxt[1];
                w_sda_oe_nxt = (w_q_nxt != Q_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge I2C_clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_scl    <= 1'b1;
            r_sda_oe <= 1'b0;
            r_newcom <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bit    <= w_bit_nxt;
            r_byte   <= w_byte_nxt;
            r_scl    <= w_scl_nxt;
            r_sda_oe <= w_sda_oe_nxt;
            r_newcom <= (w_state_nxt == ST_DONE);
            r_busy   <= (w_state_nxt != ST_IDLE);
        end
    end

    assign SCL    = r_scl;
    assign SDA_oe = r_sda_oe;
    assign NewCom = r_newcom;
    assign Busy   = r_busy;

endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: directed self-checking bench for i2c_write_master.
// Cycle k means the clock period following edge k, where edge 0 is the edge
// that samples Write high. A passive monitor decodes the bus at negedges.
module tb_i2c_write_master;

    logic       I2C_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       Write   = 1'b0;
    logic [7:0] SubAddrL = 8'h00;
    logic [7:0] data     = 8'h00;
    logic       SDA_in   = 1'b0;
    logic       SCL, SDA_oe, NewCom, Busy, AckErr;

    i2c_write_master #(.DEV_ADDR(7'h1A)) dut (
        .I2C_clk (I2C_clk),
        .reset   (reset),
        .Write   (Write),
        .SubAddrL(SubAddrL),
        .data    (data),
        .SDA_in  (SDA_in),
        .SCL     (SCL),
        .SDA_oe  (SDA_oe),
        .NewCom  (NewCom),
        .Busy    (Busy),
        .AckErr  (AckErr)
    );

    always #5 I2C_clk = ~I2C_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // bus monitor
    int   starts, stops, scl_rises;
    bit   bitq[$];
    logic prev_scl = 1'b1, prev_sda = 1'b1, mon_sda;

    always @(negedge I2C_clk) begin
        mon_sda = ~SDA_oe;
        if (!prev_scl && SCL) begin
            scl_rises = scl_rises + 1;
            bitq.push_back(mon_sda);
        end
        if (prev_scl && SCL && prev_sda && !mon_sda) starts = starts + 1;
        if (prev_scl && SCL && !prev_sda && mon_sda) stops  = stops + 1;
        prev_scl = SCL;
        prev_sda = mon_sda;
    end

    // per-cycle traces of the last command
    logic [299:0] scl_tr, oe_tr, nc_tr, busy_tr, err_tr;

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] b;
        b = 8'h00;
        if (base + 8 > bitq.size()) return 8'hxx;
        for (int i = 0; i < 8; i++) b = {b[6:0], bitq[base + i]};
        return b;
    endfunction

    function automatic int first_nc();
        for (int i = 1; i < 300; i++) if (nc_tr[i]) return i;
        return -1;
    endfunction

    function automatic int nc_count();
        int n;
        n = 0;
        for (int i = 1; i < 300; i++) if (nc_tr[i]) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge I2C_clk);
        #1;
    endtask

    // Issues one Write at edge 0 and records cycles 1..limit.
    // rst_cyc / wr_cyc: cycle during which reset / an extra Write is held.
    // hold_until > 0: Write stays high through cycle hold_until-1.
    task automatic do_cmd(input logic [7:0] sa, input logic [7:0] d, input int limit,
                          input int rst_cyc, input int wr_cyc, input int hold_until);
        starts = 0; stops = 0; scl_rises = 0; bitq.delete();
        scl_tr = '0; oe_tr = '0; nc_tr = '0; busy_tr = '0; err_tr = '0;
        SubAddrL = sa; data = d; Write = 1'b1;
        step();
        if (hold_until == 0) begin
            SubAddrL = ~sa;
            data     = ~d;
        end
        for (int c = 1; c <= limit; c++) begin
            scl_tr[c] = SCL; oe_tr[c] = SDA_oe; nc_tr[c] = NewCom;
            busy_tr[c] = Busy; err_tr[c] = AckErr;
            reset = (c == rst_cyc);
            Write = (c < hold_until) || (c == wr_cyc);
            step();
        end
        Write = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; Write = 1'b1;
        step(); step();
        n_chk++; if (SCL !== 1'b1)    begin n_fail++; $display("FAIL rst_scl got %b want 1", SCL); end
        n_chk++; if (SDA_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe got %b want 0", SDA_oe); end
        n_chk++; if (NewCom !== 1'b0) begin n_fail++; $display("FAIL rst_newcom got %b want 0", NewCom); end
        n_chk++; if (Busy !== 1'b0)   begin n_fail++; $display("FAIL rst_busy got %b want 0", Busy); end
        n_chk++; if (AckErr !== 1'b0) begin n_fail++; $display("FAIL rst_ackerr got %b want 0", AckErr); end
        reset = 1'b0; Write = 1'b0;
        step(); step();
        n_chk++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_write_lost busy got %b want 0", Busy); end
    endtask

    task automatic test_basic();
        do_cmd(8'h0C, 8'h00, 125, -1, -1, 0);
        n_chk++; if (first_nc() != 117) begin n_fail++; $display("FAIL basic_nc_cycle got %0d want 117", first_nc()); end
        n_chk++; if (nc_count() != 1)   begin n_fail++; $display("FAIL basic_nc_count got %0d want 1", nc_count()); end
        n_chk++; if (busy_tr[1] !== 1'b1 || busy_tr[117] !== 1'b1 || busy_tr[118] !== 1'b0)
            begin n_fail++; $display("FAIL basic_busy got %b%b%b want 110", busy_tr[1], busy_tr[117], busy_tr[118]); end
        n_chk++; if (oe_tr[2] !== 1'b0 || oe_tr[3] !== 1'b1 || scl_tr[4] !== 1'b1)
            begin n_fail++; $display("FAIL basic_start got oe2=%b oe3=%b scl4=%b want 0 1 1", oe_tr[2], oe_tr[3], scl_tr[4]); end
        n_chk++; if (starts != 1 || stops != 1) begin n_fail++; $display("FAIL basic_startstop got %0d/%0d want 1/1", starts, stops); end
        n_chk++; if (scl_rises != 28) begin n_fail++; $display("FAIL basic_scl_rises got %0d want 28", scl_rises); end
        n_chk++; if (get_byte(0) !== 8'h34)  begin n_fail++; $display("FAIL basic_byte0 got %h want 34", get_byte(0)); end
        n_chk++; if (get_byte(9) !== 8'h0C)  begin n_fail++; $display("FAIL basic_byte1 got %h want 0c", get_byte(9)); end
        n_chk++; if (get_byte(18) !== 8'h00) begin n_fail++; $display("FAIL basic_byte2 got %h want 00", get_byte(18)); end
        n_chk++; if (err_tr[117] !== 1'b0) begin n_fail++; $display("FAIL basic_ackerr got %b want 0", err_tr[117]); end
    endtask

    task automatic test_pattern();
        do_cmd(8'hA5, 8'h3C, 125, -1, -1, 0);
        n_chk++; if (get_byte(9) !== 8'hA5)  begin n_fail++; $display("FAIL pat_byte1 got %h want a5", get_byte(9)); end
        n_chk++; if (get_byte(18) !== 8'h3C) begin n_fail++; $display("FAIL pat_byte2 got %h want 3c", get_byte(18)); end
        // first address bit is 0: SDA pulled for the whole slot, SCL low then high
        n_chk++; if (oe_tr[5] !== 1'b1 || oe_tr[8] !== 1'b1 || scl_tr[6] !== 1'b0 || scl_tr[7] !== 1'b1)
            begin n_fail++; $display("FAIL pat_bit7 got oe5=%b oe8=%b scl6=%b scl7=%b want 1 1 0 1", oe_tr[5], oe_tr[8], scl_tr[6], scl_tr[7]); end
        n_chk++; if (oe_tr[113] !== 1'b1 || scl_tr[113] !== 1'b0 || scl_tr[115] !== 1'b1 || oe_tr[115] !== 1'b1 || oe_tr[116] !== 1'b0)
            begin n_fail++; $display("FAIL pat_stop got oe113=%b scl113=%b scl115=%b oe115=%b oe116=%b want 1 0 1 1 0",
                                     oe_tr[113], scl_tr[113], scl_tr[115], oe_tr[115], oe_tr[116]); end
        n_chk++; if (first_nc() != 117) begin n_fail++; $display("FAIL pat_nc_cycle got %0d want 117", first_nc()); end
    endtask

    task automatic test_back_to_back();
        do_cmd(8'h12, 8'h34, 250, -1, -1, 200);
        n_chk++; if (nc_count() != 2) begin n_fail++; $display("FAIL b2b_nc_count got %0d want 2", nc_count()); end
        n_chk++; if (nc_tr[117] !== 1'b1 || nc_tr[235] !== 1'b1)
            begin n_fail++; $display("FAIL b2b_nc_cycles got %b %b want 1 1", nc_tr[117], nc_tr[235]); end
        n_chk++; if (busy_tr[118] !== 1'b0 || busy_tr[119] !== 1'b1)
            begin n_fail++; $display("FAIL b2b_restart got busy118=%b busy119=%b want 0 1", busy_tr[118], busy_tr[119]); end
        n_chk++; if (starts != 2 || stops != 2) begin n_fail++; $display("FAIL b2b_startstop got %0d/%0d want 2/2", starts, stops); end
        n_chk++; if (get_byte(37) !== 8'h12 || get_byte(46) !== 8'h34)
            begin n_fail++; $display("FAIL b2b_second got %h %h want 12 34", get_byte(37), get_byte(46)); end
    endtask

    task automatic test_nack();
        SDA_in = 1'b1;
        do_cmd(8'h0C, 8'h55, 125, -1, -1, 0);
`ifdef I2C_ACK_CHECK_EN
        n_chk++; if (err_tr[39] !== 1'b0 || err_tr[40] !== 1'b1)
            begin n_fail++; $display("FAIL nack_flag got c39=%b c40=%b want 0 1", err_tr[39], err_tr[40]); end
        n_chk++; if (first_nc() != 45) begin n_fail++; $display("FAIL nack_nc_cycle got %0d want 45", first_nc()); end
        n_chk++; if (oe_tr[41] !== 1'b1 || scl_tr[41] !== 1'b0 || oe_tr[44] !== 1'b0 || scl_tr[44] !== 1'b1)
            begin n_fail++; $display("FAIL nack_stop got oe41=%b scl41=%b oe44=%b scl44=%b want 1 0 0 1", oe_tr[41], scl_tr[41], oe_tr[44], scl_tr[44]); end
        n_chk++; if (scl_rises != 10 || stops != 1)
            begin n_fail++; $display("FAIL nack_no_more_scl got rises=%0d stops=%0d want 10 1", scl_rises, stops); end
        n_chk++; if (AckErr !== 1'b1) begin n_fail++; $display("FAIL nack_sticky got %b want 1", AckErr); end
        SDA_in = 1'b0;
        do_cmd(8'h0C, 8'h55, 125, -1, -1, 0);
        n_chk++; if (err_tr[1] !== 1'b0 || first_nc() != 117)
            begin n_fail++; $display("FAIL nack_clear got err=%b nc=%0d want 0 117", err_tr[1], first_nc()); end
`else
        n_chk++; if (first_nc() != 117) begin n_fail++; $display("FAIL nack_nc_cycle got %0d want 117", first_nc()); end
        n_chk++; if (err_tr[117] !== 1'b0 || AckErr !== 1'b0)
            begin n_fail++; $display("FAIL nack_ackerr got %b %b want 0 0", err_tr[117], AckErr); end
        n_chk++; if (scl_rises != 28 || get_byte(18) !== 8'h55)
            begin n_fail++; $display("FAIL nack_full got rises=%0d byte2=%h want 28 55", scl_rises, get_byte(18)); end
        SDA_in = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        do_cmd(8'h0C, 8'h00, 125, 60, -1, 0);
        n_chk++; if (busy_tr[60] !== 1'b1) begin n_fail++; $display("FAIL rmid_busy60 got %b want 1", busy_tr[60]); end
        n_chk++; if (scl_tr[61] !== 1'b1 || oe_tr[61] !== 1'b0 || busy_tr[61] !== 1'b0)
            begin n_fail++; $display("FAIL rmid_release got scl=%b oe=%b busy=%b want 1 0 0", scl_tr[61], oe_tr[61], busy_tr[61]); end
        n_chk++; if (nc_count() != 0) begin n_fail++; $display("FAIL rmid_no_newcom got %0d want 0", nc_count()); end
        do_cmd(8'h0C, 8'h77, 125, -1, -1, 0);
        n_chk++; if (first_nc() != 117 || get_byte(18) !== 8'h77 || starts != 1)
            begin n_fail++; $display("FAIL rmid_recover got nc=%0d byte2=%h starts=%0d want 117 77 1", first_nc(), get_byte(18), starts); end
    endtask

    task automatic test_write_ignored();
        do_cmd(8'hA5, 8'h3C, 125, -1, 50, 0);
        n_chk++; if (nc_count() != 1 || first_nc() != 117)
            begin n_fail++; $display("FAIL wign_nc got count=%0d first=%0d want 1 117", nc_count(), first_nc()); end
        n_chk++; if (get_byte(0) !== 8'h34 || get_byte(9) !== 8'hA5 || get_byte(18) !== 8'h3C)
            begin n_fail++; $display("FAIL wign_bytes got %h %h %h want 34 a5 3c", get_byte(0), get_byte(9), get_byte(18)); end
        n_chk++; if (busy_tr[119] !== 1'b0 || starts != 1)
            begin n_fail++; $display("FAIL wign_no_restart got busy=%b starts=%0d want 0 1", busy_tr[119], starts); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pattern();
        test_back_to_back();
        test_nack();
        test_reset_mid();
        test_write_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
